vga_tile_ctrl: RTL and testbench

- Parametrised tile-mapped VGA controller; next generation of the fixed 20x15, 640x480 tile display in the ARM single-cycle top.
- Generates sync timing from parameters and issues one tile address per pixel to a synchronous tile memory with configurable read latency.
- Realigns sync and blank to the returned tile colour, then drives registered RGB and sync outputs.
- Provides a one-cycle frame_start pulse and a vblank level so the CPU can update the tile RAM during vertical blank without tearing.

---
 rtl/vga_tile_ctrl.sv | 179 +++++++++++++++++
 tb/tb_vga_tile_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_tile_ctrl.sv
// Parametrised tile-mapped VGA controller: sync timing, tile addressing, colour realignment.
// Optional blinking tile cursor when VGA_CURSOR_EN is defined. vdata must carry the word for a
// counter position MEM_LAT strobes after that position (the vaddr register is the first of those).
module vga_tile_ctrl #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int TILE_SHIFT = 5,
    parameter int COLS       = 20,
    parameter int ROWS       = 15,
    parameter int ADDR_W     = 9,
    parameter int CH_BITS    = 2,
    parameter int DATA_W     = 8,
    parameter int MEM_LAT    = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pix_en,
    input  logic [DATA_W-1:0]         vdata,
`ifdef VGA_CURSOR_EN
    input  logic [$clog2(COLS)-1:0]   cursor_col,
    input  logic [$clog2(ROWS)-1:0]   cursor_row,
`endif
    output logic [ADDR_W-1:0]         vaddr,
    output logic [3:0]                vga_r,
    output logic [3:0]                vga_g,
    output logic [3:0]                vga_b,
    output logic                      vga_hs_o,
    output logic                      vga_vs_o,
    output logic                      frame_start,
    output logic                      vblank
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HC_W    = $clog2(H_TOTAL);
    localparam int VC_W    = $clog2(V_TOTAL);
    localparam int TC_W    = HC_W - TILE_SHIFT;
    localparam int TR_W    = VC_W - TILE_SHIFT;
    localparam int CW      = 3 * CH_BITS;

    typedef struct packed {
        logic hs;
        logic vs;
        logic vis;
        logic cur;
    } sb_t;

    logic [HC_W-1:0]   h_cnt;
    logic [VC_W-1:0]   v_cnt;
    logic [ADDR_W-1:0] row_base;
    logic [TC_W-1:0]   tile_col;
    logic [TR_W-1:0]   tile_row;
    logic              h_last, v_last, at_origin;
    logic              active, tile_valid, vis;
    logic              cur_hit;
    sb_t               sb_d;
    sb_t               sb_q [MEM_LAT];
    sb_t               sb_last;
    logic [CW-1:0]     colour;
    logic              unused_vdata;

    assign tile_col   = h_cnt[HC_W-1:TILE_SHIFT];
    assign tile_row   = v_cnt[VC_W-1:TILE_SHIFT];
    assign h_last     = int'(h_cnt) == H_TOTAL - 1;
    assign v_last     = int'(v_cnt) == V_TOTAL - 1;
    assign at_origin  = (h_cnt == '0) && (v_cnt == '0);
    assign active     = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
    assign tile_valid = (int'(tile_col) < COLS) && (int'(tile_row) < ROWS);
    assign vis        = active && tile_valid;
    assign vblank     = int'(v_cnt) >= V_ACTIVE;
    assign unused_vdata = ^vdata;

    // row_base tracks tile_row*COLS; it keeps counting past the tile area but is masked by vis there
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            row_base <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                h_cnt <= '0;
                if (v_last) begin
                    v_cnt    <= '0;
                    row_base <= '0;
                end else begin
                    v_cnt <= v_cnt + 1'b1;
                    if (&v_cnt[TILE_SHIFT-1:0])
                        row_base <= row_base + ADDR_W'(COLS);
                end
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

`ifdef VGA_CURSOR_EN
    logic [5:0]              frame_cnt;
    logic [$clog2(COLS)-1:0] cur_col_q, col_sel;
    logic [$clog2(ROWS)-1:0] cur_row_q, row_sel;
    logic                    blink_q, blink_sel;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt <= '0;
            cur_col_q <= '0;
            cur_row_q <= '0;
            blink_q   <= 1'b0;
        end else if (pix_en && at_origin) begin
            frame_cnt <= frame_cnt + 1'b1;
            cur_col_q <= cursor_col;
            cur_row_q <= cursor_row;
            blink_q   <= ~frame_cnt[5];
        end
    end

    // the first pixel of a frame already belongs to the newly sampled cursor and blink phase
    assign col_sel   = at_origin ? cursor_col : cur_col_q;
    assign row_sel   = at_origin ? cursor_row : cur_row_q;
    assign blink_sel = at_origin ? ~frame_cnt[5] : blink_q;
    assign cur_hit   = blink_sel && (int'(col_sel) < COLS) && (int'(row_sel) < ROWS) &&
                       (int'(tile_col) == int'(col_sel)) && (int'(tile_row) == int'(row_sel));
`else
    assign cur_hit = 1'b0;
`endif

    always_comb begin
        sb_d     = '0;
        sb_d.hs  = (int'(h_cnt) >= H_ACTIVE + H_FP) && (int'(h_cnt) < H_ACTIVE + H_FP + H_SYNC);
        sb_d.vs  = (int'(v_cnt) >= V_ACTIVE + V_FP) && (int'(v_cnt) < V_ACTIVE + V_FP + V_SYNC);
        sb_d.vis = vis;
        sb_d.cur = cur_hit;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vaddr <= '0;
            for (int i = 0; i < MEM_LAT; i++)
                sb_q[i] <= '0;
        end else if (pix_en) begin
            vaddr   <= vis ? row_base + ADDR_W'(tile_col) : '0;
            sb_q[0] <= sb_d;
            for (int i = 1; i < MEM_LAT; i++)
                sb_q[i] <= sb_q[i-1];
        end
    end

    assign sb_last = sb_q[MEM_LAT-1];
    assign colour  = vdata[CW-1:0] ^ {CW{sb_last.cur}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vga_r    <= '0;
            vga_g    <= '0;
            vga_b    <= '0;
            vga_hs_o <= 1'b1;
            vga_vs_o <= 1'b1;
        end else if (pix_en) begin
            vga_r    <= sb_last.vis ? (4'(colour[CW-1 -: CH_BITS]) << (4 - CH_BITS)) : 4'h0;
            vga_g    <= sb_last.vis ? (4'(colour[2*CH_BITS-1 -: CH_BITS]) << (4 - CH_BITS)) : 4'h0;
            vga_b    <= sb_last.vis ? (4'(colour[CH_BITS-1:0]) << (4 - CH_BITS)) : 4'h0;
            vga_hs_o <= ~sb_last.hs;
            vga_vs_o <= ~sb_last.vs;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            frame_start <= 1'b0;
        else
            frame_start <= pix_en && at_origin;
    end

endmodule

// File: tb/tb_vga_tile_ctrl.sv
// Directed bench: default-timing instance (MEM_LAT=1) and a miniature-timing instance (MEM_LAT=3)
// driven from shared clock, reset and pixel strobe; n counts strobes since reset release.
module tb_vga_tile_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, pix_en, use_const;

    logic [7:0] d_vdata;
    logic [8:0] d_vaddr;
    logic [3:0] d_r, d_g, d_b;
    logic       d_hs, d_vs, d_fs, d_vb;

    logic [7:0] s_vdata;
    logic [3:0] s_vaddr, s_q1, s_q2;
    logic [3:0] s_r, s_g, s_b;
    logic       s_hs, s_vs, s_fs, s_vb;

`ifdef VGA_CURSOR_EN
    logic [4:0] d_ccol;
    logic [3:0] d_crow;
    logic [2:0] s_ccol;
    logic [0:0] s_crow;
`endif

    // default instance: combinational tile memory; miniature: two strobe-enabled stages after vaddr
    assign d_vdata = use_const ? 8'h36 : {2'b00, d_vaddr[5:0]};
    always @(posedge clk) if (pix_en) begin
        s_q1 <= s_vaddr;
        s_q2 <= s_q1;
    end
    assign s_vdata = {4'b0000, s_q2};

    vga_tile_ctrl u_def (
        .clk(clk), .reset(reset), .pix_en(pix_en), .vdata(d_vdata),
`ifdef VGA_CURSOR_EN
        .cursor_col(d_ccol), .cursor_row(d_crow),
`endif
        .vaddr(d_vaddr), .vga_r(d_r), .vga_g(d_g), .vga_b(d_b),
        .vga_hs_o(d_hs), .vga_vs_o(d_vs), .frame_start(d_fs), .vblank(d_vb)
    );

    vga_tile_ctrl #(
        .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .TILE_SHIFT(2), .COLS(5), .ROWS(2), .ADDR_W(4),
        .CH_BITS(2), .DATA_W(8), .MEM_LAT(3)
    ) u_small (
        .clk(clk), .reset(reset), .pix_en(pix_en), .vdata(s_vdata),
`ifdef VGA_CURSOR_EN
        .cursor_col(s_ccol), .cursor_row(s_crow),
`endif
        .vaddr(s_vaddr), .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
        .vga_hs_o(s_hs), .vga_vs_o(s_vs), .frame_start(s_fs), .vblank(s_vb)
    );

    int total = 0;
    int bad   = 0;
    int n     = 0;
    bit slow  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic en);
        pix_en = en;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic strobe();
        if (slow) repeat (3) cyc(1'b0);
        cyc(1'b1);
        n++;
    endtask

    task automatic run_to(input int t);
        while (n < t) strobe();
    endtask

    task automatic idle3();
        repeat (3) cyc(1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        pix_en = 1'b1;
        use_const = 1'b0;
`ifdef VGA_CURSOR_EN
        d_ccol = 5'd25; d_crow = 4'd0;
        s_ccol = 3'd3;  s_crow = 1'b1;
`endif
        repeat (3) @(negedge clk);
        chk("rst_vaddr", d_vaddr, 0);
        chk("rst_rgb", {d_r, d_g, d_b}, 0);
        chk("rst_hs", d_hs, 1);
        chk("rst_vs", d_vs, 1);
        chk("rst_fs", d_fs, 0);
        chk("rst_vblank", d_vb, 0);
        chk("rst_s_vs", s_vs, 1);

        reset = 1'b1;
        n = 0;
        run_to(1);
        chk("d_fs_first", d_fs, 1);
        chk("s_fs_first", s_fs, 1);
        chk("d_hs_first", d_hs, 1);
        run_to(2);
        chk("d_fs_pulse_end", d_fs, 0);

        run_to(25);  chk("s_hs_25", s_hs, 1);
        run_to(26);  chk("s_hs_26", s_hs, 0);
        run_to(28);  chk("s_hs_28", s_hs, 0);
        run_to(29);  chk("s_hs_29", s_hs, 1);
        run_to(32);  chk("d_vaddr_h31", d_vaddr, 0);
        run_to(33);  chk("d_vaddr_h32", d_vaddr, 1);
        run_to(35);  chk("d_rgb_h33", {d_r, d_g, d_b}, 12'h004);
`ifdef VGA_CURSOR_EN
        run_to(128); chk("s_cursor_f0", {s_r, s_g, s_b}, 12'hC4C);
`endif
        run_to(216); chk("s_vaddr_last_tile", s_vaddr, 9);
        run_to(217); chk("s_vaddr_blank", s_vaddr, 0);
        run_to(219); chk("s_rgb_last_tile", {s_r, s_g, s_b}, 12'h084);
        run_to(220); chk("s_rgb_blank", {s_r, s_g, s_b}, 12'h000);
        run_to(223); chk("s_vblank_v7", s_vb, 0);
        run_to(224); chk("s_vblank_v8", s_vb, 1);
        run_to(255); chk("s_vs_255", s_vs, 1);
        run_to(256); chk("s_vs_256", s_vs, 0);
        run_to(311); chk("s_vs_311", s_vs, 0);
        run_to(312); chk("s_vs_312", s_vs, 1);
        run_to(336); chk("s_fs_336", s_fs, 0);
        run_to(337); chk("s_fs_337", s_fs, 1);
        run_to(609); chk("d_vaddr_19", d_vaddr, 19);
        run_to(610); chk("d_rgb_h608", {d_r, d_g, d_b}, 12'h40C);
        run_to(641);
        chk("d_vaddr_h640", d_vaddr, 0);
        chk("d_rgb_h639", {d_r, d_g, d_b}, 12'h40C);
        run_to(642); chk("d_rgb_h640", {d_r, d_g, d_b}, 12'h000);
        run_to(657); chk("d_hs_657", d_hs, 1);
        run_to(658); chk("d_hs_658", d_hs, 0);
        run_to(753); chk("d_hs_753", d_hs, 0);
        run_to(754); chk("d_hs_754", d_hs, 1);
        run_to(801);
        chk("d_fs_line1", d_fs, 0);
        chk("d_vblank_line1", d_vb, 0);

        run_to(820);
        slow = 1'b1;
        run_to(832); chk("slow_vaddr_832", d_vaddr, 0);
        run_to(833); chk("slow_vaddr_833", d_vaddr, 1);
        idle3();     chk("hold_vaddr_833", d_vaddr, 1);
        run_to(1457); chk("slow_hs_1457", d_hs, 1);
        idle3();      chk("hold_hs_1457", d_hs, 1);
        run_to(1458); chk("slow_hs_1458", d_hs, 0);
        idle3();      chk("hold_hs_1458", d_hs, 0);
        chk("hold_fs_low", d_fs, 0);
        run_to(1460);
        slow = 1'b0;

`ifdef VGA_CURSOR_EN
        run_to(10544); chk("s_cursor_f31", {s_r, s_g, s_b}, 12'hC4C);
        run_to(10880); chk("s_cursor_f32", {s_r, s_g, s_b}, 12'h080);
        run_to(11000);
        s_ccol = 3'd6;
        run_to(21632); chk("s_cursor_oob_f64", {s_r, s_g, s_b}, 12'h080);
`endif
        run_to(25600); chk("d_vaddr_line31_end", d_vaddr, 0);
        run_to(25601);
        chk("d_vaddr_line32", d_vaddr, 20);
        use_const = 1'b1;
        run_to(25603); chk("d_rgb_const", {d_r, d_g, d_b}, 12'hC48);
        use_const = 1'b0;
        run_to(25633); chk("d_vaddr_line32_h32", d_vaddr, 21);

        run_to(25800);
        chk("s_vblank_pre_rst", s_vb, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_vaddr", d_vaddr, 0);
        chk("mid_rst_rgb", {d_r, d_g, d_b}, 0);
        chk("mid_rst_hs", d_hs, 1);
        chk("mid_rst_s_vs", s_vs, 1);
        chk("mid_rst_s_vblank", s_vb, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        n = 0;
        run_to(1);
        chk("restart_d_fs", d_fs, 1);
        chk("restart_s_fs", s_fs, 1);
        run_to(33); chk("restart_vaddr", d_vaddr, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
